// File: rtl/uart_tx_sched_if.sv
// rtl/uart_tx_sched_if.sv - requester, overflow and buart tx signals of uart_tx_sched
interface uart_tx_sched_if;
  logic       a_wr;
  logic [7:0] a_data;
  logic       a_full;
  logic       a_empty;
  logic       b_wr;
  logic [7:0] b_data;
  logic       b_full;
  logic       b_empty;
  logic       ovf_clr;
  logic       a_ovf;
  logic       b_ovf;
  logic       tx_wr;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       grant_b;

  modport master (
    output a_wr, a_data, b_wr, b_data, ovf_clr, tx_busy,
    input  a_full, a_empty, b_full, b_empty, a_ovf, b_ovf, tx_wr, tx_data, grant_b
  );

  modport slave (
    input  a_wr, a_data, b_wr, b_data, ovf_clr, tx_busy,
    output a_full, a_empty, b_full, b_empty, a_ovf, b_ovf, tx_wr, tx_data, grant_b
  );
endinterface

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin scheduler sharing one buart transmitter between two byte FIFOs
module uart_tx_sched #(
  parameter int DEPTH_LOG2 = 2,
  parameter int GUARD      = 1
) (
  input logic            clk,
  input logic            resetq,
  uart_tx_sched_if.slave bus
);
  localparam int AW    = DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, WAIT_START, WAIT_DONE} state_t;

  logic [1:0] push, pop, full, empty, ovf;
  logic [7:0] push_data [2];
  logic [7:0] head [2];
  logic       issue, sel_b;

  state_t     state_q;
  logic [2:0] guard_q;
  logic       tx_wr_q;
  logic [7:0] tx_data_q;
  logic       grant_b_q;

  assign push         = {bus.b_wr, bus.a_wr};
  assign push_data[0] = bus.a_data;
  assign push_data[1] = bus.b_data;

  // index 0 is requester A, index 1 is requester B
  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic          full_q, empty_q, ovf_q, accept;

    // a pop on the same edge frees the slot, so a push into a full FIFO still lands
    assign accept  = push[g] & (~full_q | pop[g]);
    assign wptr_d  = wptr_q + PW'(accept);
    assign rptr_d  = rptr_q + PW'(pop[g]);
    assign head[g] = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
      if (accept) mem_q[wptr_q[AW-1:0]] <= push_data[g];
    end

    always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        full_q  <= 1'b0;
        empty_q <= 1'b1;
        ovf_q   <= 1'b0;
      end else begin
        wptr_q  <= wptr_d;
        rptr_q  <= rptr_d;
        empty_q <= (wptr_d == rptr_d);
        full_q  <= (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
        if (push[g] && full_q && !pop[g]) ovf_q <= 1'b1;
        else if (bus.ovf_clr)             ovf_q <= 1'b0;
      end
    end

    assign full[g]  = full_q;
    assign empty[g] = empty_q;
    assign ovf[g]   = ovf_q;
  end

  // with both FIFOs pending, the source that did not win last time goes next
  always_comb begin
    issue = (state_q == IDLE) && !bus.tx_busy && (!empty[0] || !empty[1]);
    sel_b = !empty[1] && (empty[0] || !grant_b_q);
    pop   = {issue & sel_b, issue & ~sel_b};
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state_q   <= IDLE;
      guard_q   <= '0;
      tx_wr_q   <= 1'b0;
      tx_data_q <= 8'h00;
      grant_b_q <= 1'b1;
    end else begin
      tx_wr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (issue) begin
            tx_wr_q   <= 1'b1;
            tx_data_q <= sel_b ? head[1] : head[0];
            grant_b_q <= sel_b;
            guard_q   <= '0;
            state_q   <= WAIT_START;
          end
        end
        WAIT_START: begin
          // buart raises busy a little after the strobe, so busy is not trusted yet
          if (guard_q == 3'(GUARD - 1)) state_q <= WAIT_DONE;
          else                          guard_q <= guard_q + 3'd1;
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.a_full  = full[0];
  assign bus.b_full  = full[1];
  assign bus.a_empty = empty[0];
  assign bus.b_empty = empty[1];
  assign bus.a_ovf   = ovf[0];
  assign bus.b_ovf   = ovf[1];
  assign bus.tx_wr   = tx_wr_q;
  assign bus.tx_data = tx_data_q;
  assign bus.grant_b = grant_b_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - directed bench with per-source byte scoreboard and buart busy model
module tb_uart_tx_sched;
  localparam int G = 1;

  logic clk;
  logic resetq;
  logic force_busy;
  int   busy_cnt;
  int   n_cmp, n_bad, n_strobe, cyc, last_cyc, base;
  bit   have_last;
  bit   model_grant;
  bit   sel;
  bit [7:0] exp_byte;
  bit [7:0] qa[$];
  bit [7:0] qb[$];
  bit [7:0] log_q[$];
  bit       glog[$];

  uart_tx_sched_if bus ();

  uart_tx_sched #(.DEPTH_LOG2(2), .GUARD(G)) dut (
    .clk    (clk),
    .resetq (resetq),
    .bus    (bus)
  );

  assign bus.tx_busy = force_busy | (busy_cnt != 0);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_strobes(input int target, input int budget);
    for (int i = 0; i < budget && n_strobe < target; i++) tick();
    chk("strobe_count", n_strobe, target);
  endtask

  task automatic do_reset();
    resetq = 1'b0;
    qa.delete();
    qb.delete();
    log_q.delete();
    glog.delete();
    model_grant = 1'b1;
    tick();
    tick();
    resetq = 1'b1;
    tick();
  endtask

  // buart model plus output scoreboard; busy rises right after each strobe
  always @(negedge clk) begin
    cyc++;
    if (!resetq) begin
      busy_cnt  = 0;
      have_last = 1'b0;
    end else if (bus.tx_wr === 1'b1) begin
      n_strobe++;
      if (have_last) chk("strobe_spacing_ok", (cyc - last_cyc) >= (G + 2), 1);
      have_last = 1'b1;
      last_cyc  = cyc;
      chk("strobe_has_pending", (qa.size() + qb.size()) != 0, 1);
      if ((qa.size() + qb.size()) != 0) begin
        sel      = (qb.size() != 0) && ((qa.size() == 0) || !model_grant);
        exp_byte = sel ? qb.pop_front() : qa.pop_front();
        chk("tx_data", bus.tx_data, exp_byte);
        chk("grant_b", bus.grant_b, sel);
        model_grant = sel;
      end
      log_q.push_back(bus.tx_data);
      glog.push_back(bus.grant_b);
      busy_cnt = 20;
    end else if (busy_cnt != 0) begin
      busy_cnt--;
    end
  end

  initial begin
    n_cmp = 0; n_bad = 0; n_strobe = 0; cyc = 0; last_cyc = 0;
    busy_cnt = 0; have_last = 1'b0; model_grant = 1'b1;
    resetq = 1'b0; force_busy = 1'b0;
    bus.a_wr = 1'b0; bus.a_data = 8'h00;
    bus.b_wr = 1'b0; bus.b_data = 8'h00;
    bus.ovf_clr = 1'b0;

    // reset values
    tick();
    tick();
    chk("rst_a_empty", bus.a_empty, 1);
    chk("rst_b_empty", bus.b_empty, 1);
    chk("rst_a_full", bus.a_full, 0);
    chk("rst_b_full", bus.b_full, 0);
    chk("rst_a_ovf", bus.a_ovf, 0);
    chk("rst_b_ovf", bus.b_ovf, 0);
    chk("rst_tx_wr", bus.tx_wr, 0);
    chk("rst_tx_data", bus.tx_data, 8'h00);
    chk("rst_grant_b", bus.grant_b, 1);
    resetq = 1'b1;
    tick();
    chk("post_rst_tx_wr", bus.tx_wr, 0);

    // single byte: push at edge 0, strobe in the cycle after edge 1
    bus.a_wr = 1'b1; bus.a_data = 8'h41; qa.push_back(8'h41);
    tick();
    bus.a_wr = 1'b0;
    chk("single_a_empty", bus.a_empty, 0);
    chk("single_no_early_strobe", bus.tx_wr, 0);
    tick();
    chk("single_tx_wr", bus.tx_wr, 1);
    chk("single_tx_data", bus.tx_data, 8'h41);
    chk("single_grant_b", bus.grant_b, 0);
    tick();
    chk("single_strobe_one_cycle", bus.tx_wr, 0);
    chk("single_data_hold", bus.tx_data, 8'h41);
    repeat (30) tick();
    chk("single_strobe_total", n_strobe, 1);

    // round robin from a fresh reset
    do_reset();
    force_busy = 1'b1;
    tick();
    bus.a_wr = 1'b1; bus.a_data = 8'h10; qa.push_back(8'h10);
    bus.b_wr = 1'b1; bus.b_data = 8'h20; qb.push_back(8'h20);
    tick();
    bus.a_data = 8'h11; qa.push_back(8'h11);
    bus.b_data = 8'h21; qb.push_back(8'h21);
    tick();
    bus.a_wr = 1'b0; bus.b_wr = 1'b0;
    chk("rr_a_empty", bus.a_empty, 0);
    chk("rr_b_empty", bus.b_empty, 0);
    chk("rr_a_full", bus.a_full, 0);
    chk("rr_no_strobe_while_busy", n_strobe, 1);
    base = n_strobe;
    force_busy = 1'b0;
    wait_strobes(base + 4, 300);
    chk("rr_log_size", log_q.size(), 4);
    if (log_q.size() == 4) begin
      chk("rr_order0", log_q[0], 8'h10);
      chk("rr_order1", log_q[1], 8'h20);
      chk("rr_order2", log_q[2], 8'h11);
      chk("rr_order3", log_q[3], 8'h21);
      chk("rr_grant0", glog[0], 0);
      chk("rr_grant1", glog[1], 1);
      chk("rr_grant2", glog[2], 0);
      chk("rr_grant3", glog[3], 1);
    end

    // overflow on A with the UART held busy
    do_reset();
    force_busy = 1'b1;
    tick();
    for (int i = 1; i <= 5; i++) begin
      bus.a_wr = 1'b1; bus.a_data = 8'(i);
      if (i <= 4) qa.push_back(8'(i));
      tick();
      if (i == 3) chk("ovf_not_full_at_3", bus.a_full, 0);
      if (i == 4) begin
        chk("ovf_full_at_4", bus.a_full, 1);
        chk("ovf_clear_at_4", bus.a_ovf, 0);
      end
    end
    bus.a_wr = 1'b0;
    chk("ovf_set", bus.a_ovf, 1);
    chk("ovf_still_full", bus.a_full, 1);
    chk("ovf_b_untouched", bus.b_ovf, 0);
    bus.a_wr = 1'b1; bus.a_data = 8'h77; bus.ovf_clr = 1'b1;
    tick();
    bus.a_wr = 1'b0;
    chk("ovf_set_beats_clr", bus.a_ovf, 1);
    tick();
    bus.ovf_clr = 1'b0;
    chk("ovf_cleared", bus.a_ovf, 0);

    // push and pop on the same edge while full
    base = n_strobe;
    force_busy = 1'b0;
    bus.a_wr = 1'b1; bus.a_data = 8'h06; qa.push_back(8'h06);
    tick();
    bus.a_wr = 1'b0;
    chk("pp_full_kept", bus.a_full, 1);
    chk("pp_tx_wr", bus.tx_wr, 1);
    chk("pp_first_byte", bus.tx_data, 8'h01);
    chk("pp_no_ovf", bus.a_ovf, 0);
    wait_strobes(base + 5, 400);
    chk("pp_log_size", log_q.size(), 5);
    if (log_q.size() == 5) begin
      chk("pp_out0", log_q[0], 8'h01);
      chk("pp_out1", log_q[1], 8'h02);
      chk("pp_out2", log_q[2], 8'h03);
      chk("pp_out3", log_q[3], 8'h04);
      chk("pp_out4", log_q[4], 8'h06);
    end
    chk("pp_a_empty_end", bus.a_empty, 1);

    // reset in WAIT_DONE with B still holding three bytes
    do_reset();
    force_busy = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      bus.b_wr = 1'b1; bus.b_data = 8'hC1 + 8'(i); qb.push_back(8'hC1 + 8'(i));
      tick();
    end
    bus.b_wr = 1'b0;
    base = n_strobe;
    force_busy = 1'b0;
    wait_strobes(base + 1, 20);
    repeat (5) tick();
    chk("mid_b_holds", bus.b_empty, 0);
    resetq = 1'b0;
    #1;
    chk("mid_rst_b_empty", bus.b_empty, 1);
    chk("mid_rst_tx_wr", bus.tx_wr, 0);
    chk("mid_rst_grant_b", bus.grant_b, 1);
    qa.delete();
    qb.delete();
    model_grant = 1'b1;
    tick();
    tick();
    resetq = 1'b1;
    repeat (30) tick();
    chk("mid_no_strobe_after", n_strobe, base + 1);
    chk("mid_b_empty_after", bus.b_empty, 1);

    chk("left_in_model_a", qa.size(), 0);
    chk("left_in_model_b", qb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
